// File: rtl/ifm_stream_reader_pkg.sv
// Shared conv-layer definitions: IFM geometry defaults, reader FSM
// encoding and small address/width helpers.
package ifm_stream_reader_pkg;

    localparam int DEF_IFM_SIZE    = 14;
    localparam int DEF_IFM_DEPTH   = 3;
    localparam int DEF_KERNAL_SIZE = 5;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_READ  = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    function automatic int pixel_addr(
        input int map,
        input int row,
        input int col,
        input int side
    );
        return map * side * side + row * side + col;
    endfunction

    // Counter width that stays legal when a dimension is 1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ifm_stream_reader_position_counter.sv
// Column/row/map raster counter for the IFM stream; clear wins over
// advance, and last flags the final pixel of the final map.
module ifm_position_counter
    import ifm_stream_reader_pkg::*;
#(
    parameter int IFM_SIZE  = DEF_IFM_SIZE,
    parameter int IFM_DEPTH = DEF_IFM_DEPTH,
    localparam int POS_W = idx_width(IFM_SIZE),
    localparam int MAP_W = idx_width(IFM_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic             clear,
    output logic [POS_W-1:0] col,
    output logic [POS_W-1:0] row,
    output logic [MAP_W-1:0] map,
    output logic             last
);

    logic col_end;
    logic row_end;
    logic map_end;

    assign col_end = col == POS_W'(IFM_SIZE - 1);
    assign row_end = row == POS_W'(IFM_SIZE - 1);
    assign map_end = map == MAP_W'(IFM_DEPTH - 1);
    assign last    = col_end && row_end && map_end;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            col <= '0;
            row <= '0;
            map <= '0;
        end else if (advance) begin
            col <= col_end ? '0 : col + 1'b1;
            if (col_end) begin
                row <= row_end ? '0 : row + 1'b1;
                if (row_end) begin
                    map <= map_end ? '0 : map + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ifm_stream_reader.sv
// Streams IFM pixels from RAM into the line-buffer FIFO and flags
// complete in-image KxK windows, tagged per pixel so maps never mix.
module ifm_stream_reader
    import ifm_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int IFM_SIZE    = DEF_IFM_SIZE,
    parameter int IFM_DEPTH   = DEF_IFM_DEPTH,
    parameter int KERNAL_SIZE = DEF_KERNAL_SIZE,
    localparam int ADDRESS_SIZE_IFM =
        $clog2(IFM_SIZE * IFM_SIZE * IFM_DEPTH),
    localparam int POS_W = idx_width(IFM_SIZE),
    localparam int MAP_W = idx_width(IFM_DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        stall,
    input  logic [DATA_WIDTH-1:0]       ifm_data_in,
    output logic [ADDRESS_SIZE_IFM-1:0] ifm_address,
    output logic                        ifm_read_en,
    output logic                        fifo_enable,
    output logic [DATA_WIDTH-1:0]       fifo_data_out,
    output logic                        window_valid,
    output logic [MAP_W-1:0]            ifm_index,
    output logic                        busy,
    output logic                        done
);

    state_t           state;
    logic             drain_cnt;
    logic [POS_W-1:0] col;
    logic [POS_W-1:0] row;
    logic [MAP_W-1:0] map;
    logic             last;
    logic             issue;
    logic             clear;
    logic             in_window;
    logic [POS_W-1:0] tag_col;
    logic [POS_W-1:0] tag_row;
    logic [MAP_W-1:0] tag_map;
    logic [POS_W-1:0] push_col;
    logic [POS_W-1:0] push_row;
    logic [MAP_W-1:0] push_map;

    assign issue = (state == ST_READ) && !stall;
    assign clear = (state == ST_IDLE) && start;
    assign busy  = (state == ST_READ) || (state == ST_DRAIN);

    assign fifo_data_out = ifm_data_in;

    assign in_window = fifo_enable
        && (push_row >= POS_W'(KERNAL_SIZE - 1))
        && (push_col >= POS_W'(KERNAL_SIZE - 1));

    ifm_position_counter #(
        .IFM_SIZE  (IFM_SIZE),
        .IFM_DEPTH (IFM_DEPTH)
    ) u_pos (
        .clk     (clk),
        .reset   (reset),
        .advance (issue),
        .clear   (clear),
        .col     (col),
        .row     (row),
        .map     (map),
        .last    (last)
    );

    // Tag travels with the read: issue stage, then push stage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ifm_read_en  <= 1'b0;
            fifo_enable  <= 1'b0;
            window_valid <= 1'b0;
            done         <= 1'b0;
            ifm_address  <= '0;
            ifm_index    <= '0;
            tag_col      <= '0;
            tag_row      <= '0;
            tag_map      <= '0;
            push_col     <= '0;
            push_row     <= '0;
            push_map     <= '0;
        end else begin
            ifm_read_en  <= issue;
            fifo_enable  <= ifm_read_en;
            window_valid <= in_window;
            done         <= (state == ST_DONE);
            if (issue) begin
                ifm_address <= ADDRESS_SIZE_IFM'(pixel_addr(
                    int'(map), int'(row), int'(col), IFM_SIZE));
                tag_col <= col;
                tag_row <= row;
                tag_map <= map;
            end
            if (ifm_read_en) begin
                push_col <= tag_col;
                push_row <= tag_row;
                push_map <= tag_map;
            end
            if (fifo_enable) begin
                ifm_index <= push_map;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            drain_cnt <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) state <= ST_READ;
                end
                ST_READ: begin
                    if (issue && last) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifm_stream_reader.sv
// Scenario table plus randomized back-pressure, checked against an
// event-level model of reads, pushes and window pulses.
module tb_ifm_stream_reader;

    localparam int S   = 14;
    localparam int D   = 3;
    localparam int K   = 5;
    localparam int S2  = S * S;
    localparam int N   = S2 * D;
    localparam int WIN = (S - K + 1) * (S - K + 1) * D;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] ifm_data_in = '0;
    logic [9:0]  ifm_address;
    logic        ifm_read_en;
    logic        fifo_enable;
    logic [31:0] fifo_data_out;
    logic        window_valid;
    logic [1:0]  ifm_index;
    logic        busy;
    logic        done;

    ifm_stream_reader dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stall         (stall),
        .ifm_data_in   (ifm_data_in),
        .ifm_address   (ifm_address),
        .ifm_read_en   (ifm_read_en),
        .fifo_enable   (fifo_enable),
        .fifo_data_out (fifo_data_out),
        .window_valid  (window_valid),
        .ifm_index     (ifm_index),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int addr;
    } ev_t;

    typedef struct {
        string name;
        int    stall_at;
        int    stall_len;
        int    restart_at;
        int    rst_at;
        bit    rand_stall;
        int    exp_reads;
        int    exp_wins;
        int    exp_done;
        int    exp_stall_reads;
        bit    check_span;
    } vec_t;

    int  n_vec = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  n_rd, n_push, n_win, n_done, rd_in_stall;
    int  exp_addr, first_rd_cyc, last_rd_cyc;
    int  rd_cyc[N];
    int  push_cyc[N];
    int  first_win_cyc[D];
    ev_t rdq[$];
    ev_t winq[$];

    function automatic logic [31:0] mem_word(input int a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, got, exp);
        end
    endtask

    task automatic check_idle(input string nm);
        chk({nm, ".read_en"}, int'(ifm_read_en), 0);
        chk({nm, ".fifo_en"}, int'(fifo_enable), 0);
        chk({nm, ".win"}, int'(window_valid), 0);
        chk({nm, ".busy"}, int'(busy), 0);
        chk({nm, ".done"}, int'(done), 0);
        chk({nm, ".addr"}, int'(ifm_address), 0);
        chk({nm, ".index"}, int'(ifm_index), 0);
    endtask

    task automatic clear_mon();
        n_rd = 0; n_push = 0; n_win = 0; n_done = 0;
        rd_in_stall = 0; exp_addr = 0;
        first_rd_cyc = -1; last_rd_cyc = -1;
        foreach (rd_cyc[i]) rd_cyc[i] = -1;
        foreach (push_cyc[i]) push_cyc[i] = -1;
        foreach (first_win_cyc[i]) first_win_cyc[i] = -1;
        rdq.delete();
        winq.delete();
    endtask

    // RAM: data for the presented address one cycle later.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        ifm_data_in <= ifm_read_en ?
            mem_word(int'(ifm_address)) : 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        ev_t ev;
        int  r, c;
        if (!reset) begin
            rdq.delete();
            winq.delete();
            exp_addr = 0;
        end else begin
            while (rdq.size() > 0 && rdq[0].cyc + 1 < cyc) begin
                chk("push_late", cyc, rdq[0].cyc + 1);
                void'(rdq.pop_front());
            end
            while (winq.size() > 0 && winq[0].cyc < cyc) begin
                chk("win_missing", cyc, winq[0].cyc);
                void'(winq.pop_front());
            end
            if (window_valid) begin
                n_win++;
                if (winq.size() == 0) begin
                    chk("win_unexpected", winq.size(), 1);
                end else begin
                    ev = winq.pop_front();
                    chk("win_cycle", cyc, ev.cyc);
                    chk("win_index", int'(ifm_index), ev.addr / S2);
                    if (int'(ifm_index) < D &&
                        first_win_cyc[ifm_index] < 0)
                        first_win_cyc[ifm_index] = cyc;
                end
            end
            if (fifo_enable) begin
                if (rdq.size() == 0) begin
                    chk("push_unexpected", rdq.size(), 1);
                end else begin
                    ev = rdq.pop_front();
                    n_push++;
                    chk("push_cycle", cyc, ev.cyc + 1);
                    chk("push_data", int'(fifo_data_out),
                        int'(mem_word(ev.addr)));
                    if (ev.addr < N) push_cyc[ev.addr] = cyc;
                    r = (ev.addr % S2) / S;
                    c = ev.addr % S;
                    if (r >= K - 1 && c >= K - 1)
                        winq.push_back('{cyc + 1, ev.addr});
                end
            end
            if (ifm_read_en) begin
                chk("rd_addr", int'(ifm_address), exp_addr);
                chk("rd_busy", int'(busy), 1);
                if (exp_addr < N) rd_cyc[exp_addr] = cyc;
                rdq.push_back('{cyc, int'(ifm_address)});
                exp_addr++;
                n_rd++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                last_rd_cyc = cyc;
                if (stall) rd_in_stall++;
            end
            if (done) begin
                n_done++;
                chk("done_latency", cyc - last_rd_cyc, 3);
                chk("done_reads", n_rd, N);
                chk("done_busy", int'(busy), 0);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int budget = 0;
        int stall_left = 0;
        bit stall_used = 0;
        bit restarted = 0;
        bit was_reset = 0;
        clear_mon();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (budget < 3000 && n_done == 0 && !was_reset) begin
            @(posedge clk); #1;
            budget++;
            start = 1'b0;
            stall = v.rand_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (v.stall_at >= 0 && !stall_used &&
                n_rd >= v.stall_at) begin
                stall_left = v.stall_len;
                stall_used = 1;
            end
            if (stall_left > 0) begin
                stall = 1'b1;
                stall_left--;
            end
            if (v.restart_at >= 0 && !restarted &&
                n_rd >= v.restart_at) begin
                start = 1'b1;
                restarted = 1;
            end
            if (v.rst_at >= 0 && n_rd >= v.rst_at) begin
                reset = 1'b0;
                stall = 1'b0;
                start = 1'b0;
                @(negedge clk);
                @(negedge clk);
                check_idle({v.name, ".abort"});
                @(posedge clk); #1;
                reset = 1'b1;
                was_reset = 1;
            end
        end
        chk({v.name, ".in_time"}, (budget < 3000) ? 1 : 0, 1);
        stall = 1'b0;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk({v.name, ".reads"}, n_rd, v.exp_reads);
        if (v.exp_wins >= 0)
            chk({v.name, ".windows"}, n_win, v.exp_wins);
        chk({v.name, ".dones"}, n_done, v.exp_done);
        chk({v.name, ".idle_busy"}, int'(busy), 0);
        if (v.exp_stall_reads >= 0)
            chk({v.name, ".stall_reads"}, rd_in_stall, v.exp_stall_reads);
        if (!was_reset)
            chk({v.name, ".drained"}, rdq.size() + winq.size(), 0);
        if (v.check_span) begin
            chk({v.name, ".span"}, last_rd_cyc - first_rd_cyc, N - 1);
            chk({v.name, ".map_gap"}, rd_cyc[S2] - rd_cyc[S2 - 1], 1);
            chk({v.name, ".first_win0"}, first_win_cyc[0],
                push_cyc[4 * S + 4] + 1);
            chk({v.name, ".first_win1"}, first_win_cyc[1],
                push_cyc[S2 + 4 * S + 4] + 1);
        end
    endtask

    initial begin
        vec_t tbl[7];
        tbl[0] = '{"plain",    -1, 0,  -1,  -1, 0, N,   WIN, 1, -1, 1};
        tbl[1] = '{"stall",   103, 5,  -1,  -1, 0, N,   WIN, 1,  1, 0};
        tbl[2] = '{"restart",  -1, 0, 300,  -1, 0, N,   WIN, 1, -1, 0};
        tbl[3] = '{"reset",    -1, 0,  -1, 200, 0, 200,  -1, 0, -1, 0};
        tbl[4] = '{"after_rst",-1, 0,  -1,  -1, 0, N,   WIN, 1, -1, 1};
        tbl[5] = '{"rand_a",   -1, 0,  -1,  -1, 1, N,   WIN, 1, -1, 0};
        tbl[6] = '{"rand_b",   -1, 0, 150,  -1, 1, N,   WIN, 1, -1, 0};
        clear_mon();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset_state");
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 7; i++) begin
            run_vec(tbl[i]);
        end
        $display("== %0d vectors applied, %0d miscompares ==",
            n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ifm_stream_reader.md
IFM_STREAM_READER -- requirements
Module: ifm_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, pixel word width.
REQ-002 SHALL have parameter IFM_SIZE, default 14, IFM side length in pixels.
REQ-003 SHALL have parameter IFM_DEPTH, default 3, number of IFMs streamed per start.
REQ-004 SHALL have parameter KERNAL_SIZE, default 5, window side length of the downstream line-buffer FIFO.
REQ-005 SHALL have derived parameter ADDRESS_SIZE_IFM = clog2(IFM_SIZE*IFM_SIZE*IFM_DEPTH), the IFM RAM address width.
REQ-006 SHALL have port clk, input, 1, the only clock; one clock domain.
REQ-007 SHALL have port reset, input, 1, synchronous, active-low.
REQ-008 SHALL have port start, input, 1, pulse that begins one stream pass.
REQ-009 SHALL have port stall, input, 1, downstream back-pressure that blocks new reads.
REQ-010 SHALL have port ifm_data_in, input, DATA_WIDTH, IFM RAM read data, valid 1 cycle after address.
REQ-011 SHALL have port ifm_address, output, ADDRESS_SIZE_IFM, IFM RAM read address.
REQ-012 SHALL have port ifm_read_en, output, 1, IFM RAM read strobe.
REQ-013 SHALL have port fifo_enable, output, 1, shift strobe to the line-buffer FIFO.
REQ-014 SHALL have port fifo_data_out, output, DATA_WIDTH, pixel to the FIFO; equals ifm_data_in combinationally.
REQ-015 SHALL have port window_valid, output, 1, FIFO window taps hold a complete in-image KxK window.
REQ-016 SHALL have port ifm_index, output, clog2(IFM_DEPTH), map number qualifying window_valid.
REQ-017 SHALL have ports busy and done, output, 1 each: pass in progress; one-cycle completion pulse.

Function
REQ-018 SHALL have FSM states IDLE, READ, DRAIN, DONE.
REQ-019 SHALL move IDLE->READ on start=1; start SHALL be ignored outside IDLE.
REQ-020 In READ with stall=0, SHALL assert ifm_read_en, drive ifm_address = map*IFM_SIZE^2 + row*IFM_SIZE + col, then advance col, wrapping to row+1 and then to map+1.
REQ-021 In READ with stall=1, SHALL drive ifm_read_en=0 and hold all counters; a read issued the cycle before stall rises SHALL still complete.
REQ-022 SHALL assert fifo_enable exactly 1 cycle after each ifm_read_en, one pulse per pixel, with the issue-cycle row/col/map tag carried alongside.
REQ-023 SHALL assert window_valid 1 cycle after a fifo_enable whose tag has row>=KERNAL_SIZE-1 and col>=KERNAL_SIZE-1; ifm_index SHALL equal that tag's map.
REQ-024 SHALL produce exactly (IFM_SIZE-KERNAL_SIZE+1)^2 window_valid pulses per map; no pulse SHALL depend on prior-map pixels still in the FIFO.
REQ-025 SHALL issue no read between the last pixel of one map and the first of the next (no bubble).
REQ-026 SHALL move READ->DRAIN on issuing the final pixel (map=IFM_DEPTH-1, row=col=IFM_SIZE-1).
REQ-027 SHALL stay in DRAIN until the pipeline empties (2 cycles), then go to DONE.
REQ-028 SHALL pulse done in DONE for 1 cycle, then return to IDLE.
REQ-029 SHALL hold busy=1 in READ and DRAIN, else 0.

Reset
REQ-030 While reset=0 at a clk edge, SHALL force state IDLE, zero all counters and pipeline tags, and make ifm_read_en, fifo_enable, window_valid, busy, done, ifm_address and ifm_index 0 from the next cycle.
REQ-031 Reset mid-pass SHALL abort it with no done pulse; a later start SHALL restart from address 0.

Structure
REQ-032 SHALL place the FSM state encoding and the IFM_SIZE/KERNAL_SIZE/IFM_DEPTH defaults in the shared conv-layer package.
REQ-033 SHALL place the col/row/map wrap counters in one sub-module, ifm_position_counter, with inputs advance and clear, outputs col/row/map/last.

Verification
REQ-034 Defaults, start at cycle 0, stall=0 -> 588 consecutive reads at addresses 0..587, 300 window_valid pulses, first 1 cycle after the push of address 60, done 3 cycles after the last read.
REQ-035 stall=1 for 5 cycles mid-row 7 -> exactly one read during stall onset, addresses resume contiguous, window count still 300.
REQ-036 start pulsed while busy -> ignored; single done; no address reissued.
REQ-037 reset=0 after 200 reads -> next cycle all outputs 0, state IDLE, no done; new start -> address sequence restarts at 0.
REQ-038 Map boundary (address 195->196) -> no bubble; no window_valid for map 1 until its row 4 col 4 push (address 256); ifm_index=1 there.
